// File: rtl/tagged_flux_fifo_if.sv
// tagged_flux_fifo_if
//   Bundle between producer/consumer actors and the tagged multi-flux FIFO.
//   master : actor side. It drives write/din/read and observes full/empty/dout.
//   slave  : FIFO side. It observes write/din/read and drives full/empty/dout.
//   Signals:
//     write     : write strobe
//     din       : {tag, data}; the tag sits in the MSBs
//     full      : per-flux full flags
//     read      : per-flux pop requests
//     empty     : per-flux empty flags
//     dout      : head word of the selected flux
//     overflow  : sticky dropped-write flag (only with FIFO_ERR_EN)
//     underflow : sticky empty-pop flag (only with FIFO_ERR_EN)
interface tagged_flux_fifo_if #(
  parameter int FLUX       = 2,
  parameter int DATA_WIDTH = 7,
  parameter int TAG_WIDTH  = $clog2(FLUX)
);
  logic                            write;
  logic [TAG_WIDTH+DATA_WIDTH-1:0] din;
  logic [FLUX-1:0]                 full;
  logic [FLUX-1:0]                 read;
  logic [FLUX-1:0]                 empty;
  logic [DATA_WIDTH-1:0]           dout;
`ifdef FIFO_ERR_EN
  logic                            overflow;
  logic                            underflow;
`endif

  modport master (
    output write, din, read,
    input  full, empty, dout
`ifdef FIFO_ERR_EN
    , input overflow, underflow
`endif
  );

  modport slave (
    input  write, din, read,
    output full, empty, dout
`ifdef FIFO_ERR_EN
    , output overflow, underflow
`endif
  );
endinterface

// File: rtl/tagged_flux_fifo.sv
// tagged_flux_fifo
//   This block holds FLUX independent first-word-fall-through queues of DEPTH
//   words each, between dataflow actors. A tagged write {tag, data} goes to
//   queue[tag]. Each flux is popped through its own read bit. Only the lowest
//   set read bit is honoured.
//   Ports:
//     clk   : sole clock; all state changes on the rising edge
//     rst_n : asynchronous active-low reset
//     bus   : tagged_flux_fifo_if.slave (write, din, full, read, empty, dout)
//   Optional feature macro: FIFO_ERR_EN. When it is defined, the block adds the
//   sticky overflow and underflow flags on the bus.
module tagged_flux_fifo #(
  parameter int FLUX       = 2,
  parameter int DATA_WIDTH = 7,
  parameter int DEPTH      = 4,
  parameter int TAG_WIDTH  = $clog2(FLUX)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  tagged_flux_fifo_if.slave    bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] mem     [FLUX][DEPTH];
  logic [PTR_W-1:0]      wptr    [FLUX];
  logic [PTR_W-1:0]      rptr    [FLUX];
  logic [CNT_W-1:0]      cnt     [FLUX];
  logic [CNT_W-1:0]      cnt_nxt [FLUX];
  logic [FLUX-1:0]       empty_r;
  logic [FLUX-1:0]       full_r;

  logic [TAG_WIDTH-1:0]  tag;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  tag_ok;
  logic [TAG_WIDTH-1:0]  rd_idx;
  logic                  rd_any;
  logic [FLUX-1:0]       wr_en;
  logic [FLUX-1:0]       pop;
  logic [DATA_WIDTH-1:0] dout_c;

  assign tag    = bus.din[TAG_WIDTH+DATA_WIDTH-1 -: TAG_WIDTH];
  assign wdata  = bus.din[DATA_WIDTH-1:0];
  assign tag_ok = int'(tag) < FLUX;

  // Request decode: the lowest set read bit wins, so a multi-hot read is tamed
  always_comb begin
    rd_any = 1'b0;
    rd_idx = '0;
    for (int i = FLUX - 1; i >= 0; i--) begin
      if (bus.read[i]) begin
        rd_any = 1'b1;
        rd_idx = TAG_WIDTH'(i);
      end
    end
  end

  // Acceptance uses registered flags only. A full queue drops its write even
  // when it is popped in the same cycle.
  always_comb begin
    for (int i = 0; i < FLUX; i++) begin
      wr_en[i]   = bus.write && tag_ok && (int'(tag) == i) && !full_r[i];
      pop[i]     = rd_any && (int'(rd_idx) == i) && !empty_r[i];
      cnt_nxt[i] = cnt[i] + CNT_W'(wr_en[i]) - CNT_W'(pop[i]);
    end
  end

  // Output select: the requested flux head, otherwise the lowest non-empty head
  always_comb begin
    dout_c = '0;
    if (rd_any) begin
      if (!empty_r[rd_idx])
        dout_c = mem[rd_idx][rptr[rd_idx]];
    end else begin
      for (int i = FLUX - 1; i >= 0; i--) begin
        if (!empty_r[i])
          dout_c = mem[i][rptr[i]];
      end
    end
  end

  // State update: pointers, counts and flags registered from next-state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FLUX; i++) begin
        wptr[i] <= '0;
        rptr[i] <= '0;
        cnt[i]  <= '0;
      end
      empty_r <= '1;
      full_r  <= '0;
    end else begin
      for (int i = 0; i < FLUX; i++) begin
        if (wr_en[i])
          wptr[i] <= wptr[i] + PTR_W'(1);
        if (pop[i])
          rptr[i] <= rptr[i] + PTR_W'(1);
        cnt[i]     <= cnt_nxt[i];
        empty_r[i] <= (cnt_nxt[i] == '0);
        full_r[i]  <= (cnt_nxt[i] == CNT_W'(DEPTH));
      end
    end
  end

  // Storage: the words carry no reset. The counters decide what is valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < FLUX; i++) begin
      if (wr_en[i])
        mem[i][wptr[i]] <= wdata;
    end
  end

  assign bus.full  = full_r;
  assign bus.empty = empty_r;
  assign bus.dout  = dout_c;

`ifdef FIFO_ERR_EN
  logic ovf_r;
  logic unf_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_r <= 1'b0;
      unf_r <= 1'b0;
    end else begin
      if (bus.write && !(|wr_en))
        ovf_r <= 1'b1;
      if (rd_any && !(|pop))
        unf_r <= 1'b1;
    end
  end

  assign bus.overflow  = ovf_r;
  assign bus.underflow = unf_r;
`endif
endmodule

// File: tb/tb_tagged_flux_fifo.sv
module tb_tagged_flux_fifo;
  localparam int FLUX  = 2;
  localparam int DW    = 7;
  localparam int DEPTH = 4;
  localparam int TW    = 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  tagged_flux_fifo_if #(.FLUX(FLUX), .DATA_WIDTH(DW), .TAG_WIDTH(TW)) bus ();

  tagged_flux_fifo #(.FLUX(FLUX), .DATA_WIDTH(DW), .DEPTH(DEPTH), .TAG_WIDTH(TW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    bit            w;
    bit [TW-1:0]   tag;
    bit [DW-1:0]   data;
    bit [FLUX-1:0] rd;
    bit [FLUX-1:0] e;
    bit [FLUX-1:0] f;
    bit [DW-1:0]   d;
  } vec_t;

  vec_t          vecs[$];
  logic [DW-1:0] sq0[$];
  logic [DW-1:0] sq1[$];
  int            n_vec = 0;
  int            n_err = 0;

  function automatic void add(bit w, bit [TW-1:0] tag, bit [DW-1:0] data, bit [FLUX-1:0] rd,
                              bit [FLUX-1:0] e, bit [FLUX-1:0] f, bit [DW-1:0] d);
    vec_t v;
    v.w = w; v.tag = tag; v.data = data; v.rd = rd; v.e = e; v.f = f; v.d = d;
    vecs.push_back(v);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(bit w, bit [TW-1:0] tag, bit [DW-1:0] data, bit [FLUX-1:0] rd);
    @(negedge clk);
    bus.write = w;
    bus.din   = {tag, data};
    bus.read  = rd;
    #1;
  endtask

  task automatic apply_vec(vec_t v, int idx);
    int s0, s1;
    logic [DW-1:0] exp;
    drive(v.w, v.tag, v.data, v.rd);
    check($sformatf("v%0d_empty", idx), 32'(bus.empty), 32'(v.e));
    check($sformatf("v%0d_full", idx), 32'(bus.full), 32'(v.f));
    check($sformatf("v%0d_dout", idx), 32'(bus.dout), 32'(v.d));
    s0 = sq0.size();
    s1 = sq1.size();
    if (v.rd[0] && s0 > 0) begin
      exp = sq0.pop_front();
      check($sformatf("v%0d_sb_pop0", idx), 32'(bus.dout), 32'(exp));
    end else if (!v.rd[0] && v.rd[1] && s1 > 0) begin
      exp = sq1.pop_front();
      check($sformatf("v%0d_sb_pop1", idx), 32'(bus.dout), 32'(exp));
    end
    if (v.w) begin
      if (v.tag == 0 && s0 < DEPTH) sq0.push_back(v.data);
      if (v.tag == 1 && s1 < DEPTH) sq1.push_back(v.data);
    end
    @(posedge clk);
  endtask

  initial begin
    // single flux 1 word
    add(0,0,7'd0 ,2'b00,2'b11,2'b00,7'd0);
    add(1,1,7'h15,2'b00,2'b11,2'b00,7'd0);
    add(0,0,7'd0 ,2'b00,2'b01,2'b00,7'h15);
    add(0,0,7'd0 ,2'b10,2'b01,2'b00,7'h15);
    add(0,0,7'd0 ,2'b00,2'b11,2'b00,7'd0);
    // fill flux 0, overflow write, drain
    add(1,0,7'd1 ,2'b00,2'b11,2'b00,7'd0);
    add(1,0,7'd2 ,2'b00,2'b10,2'b00,7'd1);
    add(1,0,7'd3 ,2'b00,2'b10,2'b00,7'd1);
    add(1,0,7'd4 ,2'b00,2'b10,2'b00,7'd1);
    add(1,0,7'd5 ,2'b00,2'b10,2'b01,7'd1);
    add(0,0,7'd0 ,2'b00,2'b10,2'b01,7'd1);
    add(0,0,7'd0 ,2'b01,2'b10,2'b01,7'd1);
    add(0,0,7'd0 ,2'b01,2'b10,2'b00,7'd2);
    add(0,0,7'd0 ,2'b01,2'b10,2'b00,7'd3);
    add(0,0,7'd0 ,2'b01,2'b10,2'b00,7'd4);
    add(0,0,7'd0 ,2'b00,2'b11,2'b00,7'd0);
    // wrapped pointers
    add(1,0,7'd6 ,2'b00,2'b11,2'b00,7'd0);
    add(1,0,7'd7 ,2'b00,2'b10,2'b00,7'd6);
    add(0,0,7'd0 ,2'b00,2'b10,2'b00,7'd6);
    add(0,0,7'd0 ,2'b01,2'b10,2'b00,7'd6);
    add(0,0,7'd0 ,2'b01,2'b10,2'b00,7'd7);
    add(0,0,7'd0 ,2'b00,2'b11,2'b00,7'd0);
    // interleaved fluxes
    add(1,0,7'd10,2'b00,2'b11,2'b00,7'd0);
    add(1,1,7'd20,2'b00,2'b10,2'b00,7'd10);
    add(1,0,7'd11,2'b00,2'b00,2'b00,7'd10);
    add(1,1,7'd21,2'b00,2'b00,2'b00,7'd10);
    add(0,0,7'd0 ,2'b10,2'b00,2'b00,7'd20);
    add(0,0,7'd0 ,2'b10,2'b00,2'b00,7'd21);
    add(0,0,7'd0 ,2'b00,2'b10,2'b00,7'd10);
    add(0,0,7'd0 ,2'b01,2'b10,2'b00,7'd10);
    add(0,0,7'd0 ,2'b01,2'b10,2'b00,7'd11);
    add(0,0,7'd0 ,2'b00,2'b11,2'b00,7'd0);
    // same-cycle write+pop, not full
    add(1,0,7'd30,2'b00,2'b11,2'b00,7'd0);
    add(1,0,7'd31,2'b00,2'b10,2'b00,7'd30);
    add(1,0,7'd9 ,2'b01,2'b10,2'b00,7'd30);
    add(0,0,7'd0 ,2'b00,2'b10,2'b00,7'd31);
    add(0,0,7'd0 ,2'b01,2'b10,2'b00,7'd31);
    add(0,0,7'd0 ,2'b01,2'b10,2'b00,7'd9);
    add(0,0,7'd0 ,2'b00,2'b11,2'b00,7'd0);
    // same-cycle write+pop, full: write dropped
    add(1,0,7'd40,2'b00,2'b11,2'b00,7'd0);
    add(1,0,7'd41,2'b00,2'b10,2'b00,7'd40);
    add(1,0,7'd42,2'b00,2'b10,2'b00,7'd40);
    add(1,0,7'd43,2'b00,2'b10,2'b00,7'd40);
    add(1,0,7'd9 ,2'b01,2'b10,2'b01,7'd40);
    add(0,0,7'd0 ,2'b00,2'b10,2'b00,7'd41);
    add(0,0,7'd0 ,2'b01,2'b10,2'b00,7'd41);
    add(0,0,7'd0 ,2'b01,2'b10,2'b00,7'd42);
    add(0,0,7'd0 ,2'b01,2'b10,2'b00,7'd43);
    add(0,0,7'd0 ,2'b00,2'b11,2'b00,7'd0);

    rst_n     = 1'b0;
    bus.write = 1'b0;
    bus.din   = '0;
    bus.read  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 7'd0, 2'b00);
      check($sformatf("idle%0d_empty", i), 32'(bus.empty), 32'h3);
      check($sformatf("idle%0d_full", i), 32'(bus.full), 32'h0);
      check($sformatf("idle%0d_dout", i), 32'(bus.dout), 32'h0);
`ifdef FIFO_ERR_EN
      check($sformatf("idle%0d_ovf", i), 32'(bus.overflow), 32'h0);
      check($sformatf("idle%0d_unf", i), 32'(bus.underflow), 32'h0);
`endif
      @(posedge clk);
    end

    for (int i = 0; i < vecs.size(); i++)
      apply_vec(vecs[i], i);

    check("sb_q0_drained", 32'(sq0.size()), 32'h0);
    check("sb_q1_drained", 32'(sq1.size()), 32'h0);

`ifdef FIFO_ERR_EN
    drive(0, 0, 7'd0, 2'b01);
    @(posedge clk);
    drive(0, 0, 7'd0, 2'b00);
    check("err_ovf_set", 32'(bus.overflow), 32'h1);
    check("err_unf_set", 32'(bus.underflow), 32'h1);
    @(posedge clk);
`endif

    // async reset with three words queued
    drive(1, 0, 7'd60, 2'b00); @(posedge clk);
    drive(1, 0, 7'd61, 2'b00); @(posedge clk);
    drive(1, 1, 7'd62, 2'b00); @(posedge clk);
    drive(0, 0, 7'd0, 2'b00);
    check("pre_rst_empty", 32'(bus.empty), 32'h0);
    check("pre_rst_dout", 32'(bus.dout), 32'(7'd60));
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_empty", 32'(bus.empty), 32'h3);
    check("async_rst_full", 32'(bus.full), 32'h0);
    check("async_rst_dout", 32'(bus.dout), 32'h0);
`ifdef FIFO_ERR_EN
    check("async_rst_ovf", 32'(bus.overflow), 32'h0);
    check("async_rst_unf", 32'(bus.underflow), 32'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);

    drive(1, 1, 7'd55, 2'b00);
    check("post_rst_empty0", 32'(bus.empty), 32'h3);
    @(posedge clk);
    drive(0, 0, 7'd0, 2'b00);
    check("post_rst_empty1", 32'(bus.empty), 32'h1);
    check("post_rst_dout1", 32'(bus.dout), 32'(7'd55));
    @(posedge clk);
    drive(0, 0, 7'd0, 2'b10);
    check("post_rst_pop", 32'(bus.dout), 32'(7'd55));
    @(posedge clk);
    drive(0, 0, 7'd0, 2'b00);
    check("post_rst_empty2", 32'(bus.empty), 32'h3);
    check("post_rst_dout2", 32'(bus.dout), 32'h0);
    @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/tagged_flux_fifo.md
# tagged_flux_fifo

Multi-flux FIFO that sits between dataflow actors of the HEVC 8-pixel interpolation chain. It accepts tagged writes from an upstream actor's write port (`{tag, data}`) and keeps FLUX independent first-word-fall-through queues. It serves a downstream actor's read port through per-flux `empty`/`read` handshakes. It is the storage side of the write/read actor interfaces: it feeds actors such as the size-derivation stage and absorbs their output.

## Interface
Parameters:
- FLUX, 2, number of independent data fluxes; FLUX >= 2
- DATA_WIDTH, 7, payload width per word
- DEPTH, 4, words per flux queue; power of two, >= 2
- TAG_WIDTH, $clog2(FLUX), derived; tag field width in `din`

Ports (single clock; reset is asynchronous and active-low):
- clk  in  1  sole clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- write  in  1  write strobe from producer actor
- din  in  TAG_WIDTH+DATA_WIDTH  `{tag, data}`; tag in MSBs selects target queue
- full  out  FLUX  per-flux full flag, registered
- read  in  FLUX  per-flux pop request from consumer actor; one-hot or zero
- empty  out  FLUX  per-flux empty flag, registered
- dout  out  DATA_WIDTH  head word of selected queue, combinational
- overflow  out  1  sticky error flag; present only with FIFO_ERR_EN
- underflow  out  1  sticky error flag; present only with FIFO_ERR_EN

## Operation
- Each queue has its own write pointer, read pointer and occupancy counter (0..DEPTH), with log2(DEPTH)+1 bits for the counter. Pointers wrap modulo DEPTH.
- Write accepted when `write`=1, tag < FLUX and `full[tag]`=0: data stored at `wptr[tag]`, pointer++, count++.
- Write dropped (no state change except error flag) when the tag queue is full or when tag >= FLUX.
- Pop accepted when `read[i]`=1 and `empty[i]`=0: pointer++, count--. Pop of an empty queue is ignored.
- `read` with more than one bit set is illegal. Only the lowest set bit is honoured.
- dout selection:
  - head of the queue whose `read` bit is set;
  - if no `read` bit is set, head of the lowest-index non-empty queue;
  - if all queues are empty, 0.
  - dout depends on `read` and registered state only; there is no combinational path to `full`/`empty`.
- Simultaneous write and pop on the same queue in one cycle:
  - if the queue is not full, both take effect and count is unchanged;
  - if it is full, the write is dropped even though a pop occurs.
- Writes and pops on different queues are independent in the same cycle.
- `empty[i]` = (count[i]==0) and `full[i]` = (count[i]==DEPTH), both computed from next-state and registered.

## Timing
- Reset (async assert, sync-safe deassert by system): all counts and pointers = 0, `empty` = all 1s, `full` = all 0s, dout = 0, overflow = underflow = 0. Reset mid-operation discards all stored words immediately.
- Write at edge N: `empty[tag]` falls after edge N. Word is on dout from cycle N+1 (fall-through latency 1).
- Write filling the queue at edge N: `full[tag]` rises after edge N. Pop at edge M: `full` falls after edge M.
- Pop is zero-latency in the request cycle: dout shows the current head while `read` is high, and the next head appears after the edge.
- Throughput: one write and one pop per cycle sustained.

## Configuration
- FIFO_ERR_EN:
  - Defined: `overflow` latches 1 on any dropped write (full queue or tag >= FLUX). `underflow` latches 1 on any pop of an empty queue. Both clear only on reset.
  - Undefined: both ports and their logic are absent, and dropped writes or ignored pops are silent.

## Test plan
- Reset then idle: `empty`=2'b11, `full`=2'b00, dout=0 for 5 cycles; with FIFO_ERR_EN, overflow=underflow=0.
- Write 7'h15 tag 1 at edge 0 -> `empty`=2'b01 after edge 0; dout=7'h15 with read=0; read=2'b10 for one cycle -> `empty`=2'b11.
- Fill flux 0 with 1,2,3,4 (DEPTH=4) -> `full[0]`=1 after 4th write. A 5th write of 5 is dropped (overflow=1 with FIFO_ERR_EN). Pops return 1,2,3,4 in order across pointer wrap.
- Queue full on flux 0: same-cycle write of 9 and read[0]=1 -> pop of head occurs, write dropped, count 3, `full[0]`=0. Non-full case: count unchanged and 9 appears last.
- Interleaved writes: tag0 = 10,11 and tag1 = 20,21; read=2'b10 shows 20, 21 while flux 0 holds 10, 11 untouched. Ordering is per-flux FIFO.
- Assert rst_n low mid-stream with 3 words queued -> empty=all 1s immediately without a clock edge. Subsequent write/read behaves from a clean state.
